// File: rtl/nibble_stream_rx_if.sv
// Nibble link receive-side bundle: serial input strobes plus the word handshake
// and status flags presented to the consumer.
interface nibble_stream_rx_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
);

  logic                     ser_en;
  logic                     ser_data;
  logic                     frame_sync;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   fill_level;
  logic                     overflow;
  logic                     frame_err;

  // Link driver / consumer side.
  modport master (
    output ser_en,
    output ser_data,
    output frame_sync,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  fill_level,
    input  overflow,
    input  frame_err
  );

  // Receiver side.
  modport slave (
    input  ser_en,
    input  ser_data,
    input  frame_sync,
    input  out_ready,
    output out_valid,
    output out_data,
    output fill_level,
    output overflow,
    output frame_err
  );

endinterface

// File: rtl/nibble_stream_rx.sv
// Serial-to-parallel receiver for the nibble link. Enabled bits are shifted in
// LSB first, completed words are queued in a DEPTH-entry FIFO and handed to the
// consumer on a valid/ready handshake. Overflow and framing errors are sticky.
module nibble_stream_rx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  nibble_stream_rx_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Deserializer state
  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              word_done;
  logic [WIDTH-1:0]  word;
  logic              frame_err_set;

  // FIFO state
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic              overflow_q, frame_err_q;
  logic              overflow_set;

  // The completing bit goes straight into the pushed word, never into shreg.
  assign word = {bus.ser_data, shreg_q[WIDTH-2:0]};

  // Deserializer next-state: frame_sync wins over a same-cycle bit strobe.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    word_done     = 1'b0;
    frame_err_set = 1'b0;
    if (bus.frame_sync) begin
      state_d       = StIdle;
      bit_cnt_d     = '0;
      shreg_d       = '0;
      frame_err_set = (state_q == StShift);
    end else if (bus.ser_en) begin
      unique case (state_q)
        StIdle: begin
          // WIDTH >= 2, so the first bit never completes a word.
          shreg_d[bit_cnt_q] = bus.ser_data;
          bit_cnt_d          = bit_cnt_q + CntW'(1);
          state_d            = StShift;
        end
        StShift: begin
          if (bit_cnt_q == CntW'(WIDTH - 1)) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
            shreg_d   = '0;
            state_d   = StIdle;
          end else begin
            shreg_d[bit_cnt_q] = bus.ser_data;
            bit_cnt_d          = bit_cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      endcase
    end
  end

  // Deserializer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  // FIFO status and handshake decode; the extra pointer bit separates full from empty.
  always_comb begin
    fifo_empty   = (wr_ptr_q == rd_ptr_q);
    fifo_full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    pop          = !fifo_empty && bus.out_ready;
    // A full FIFO still takes a word if the head leaves in the same cycle.
    push         = word_done && (!fifo_full || pop);
    overflow_set = word_done && fifo_full && !pop;
  end

  // FIFO storage and pointers; storage is reset so out_data never shows X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[PtrW-1:0]] <= word;
        wr_ptr_q                  <= wr_ptr_q + (PtrW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (overflow_set)  overflow_q  <= 1'b1;
      if (frame_err_set) frame_err_q <= 1'b1;
    end
  end

  assign bus.out_valid  = !fifo_empty;
  assign bus.out_data   = mem_q[rd_ptr_q[PtrW-1:0]];
  assign bus.fill_level = wr_ptr_q - rd_ptr_q;
  assign bus.overflow   = overflow_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_nibble_stream_rx.sv
// Bench for nibble_stream_rx: directed scenarios plus randomized traffic, all
// checked against a queue-based model of the receiver.
module tb_nibble_stream_rx;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_stream_rx_if #(.WIDTH(W), .DEPTH(D)) bus ();

  nibble_stream_rx #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  int           m_nbits;
  logic [W-1:0] m_acc;
  logic         m_ovf;
  logic         m_ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one clock's worth of inputs to the model, mirroring the coming edge.
  task automatic model_step(input logic se, input logic sd, input logic fs, input logic rdy);
    logic         pop;
    logic         done;
    logic [W-1:0] w;
    if (rst) begin
      mq.delete();
      m_nbits = 0;
      m_acc   = '0;
      m_ovf   = 1'b0;
      m_ferr  = 1'b0;
      return;
    end
    pop  = (mq.size() > 0) && rdy;
    done = 1'b0;
    w    = '0;
    if (fs) begin
      if (m_nbits != 0) m_ferr = 1'b1;
      m_nbits = 0;
      m_acc   = '0;
    end else if (se) begin
      m_acc[m_nbits] = sd;
      m_nbits++;
      if (m_nbits == int'(W)) begin
        done    = 1'b1;
        w       = m_acc;
        m_nbits = 0;
        m_acc   = '0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (done) begin
      if (mq.size() < int'(D)) mq.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_check();
    check("valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
    check("fill", {29'd0, bus.fill_level}, mq.size());
    check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    check("frame_err", {31'd0, bus.frame_err}, {31'd0, m_ferr});
    check("data_no_x", {31'd0, $isunknown(bus.out_data)}, 32'd0);
    if (mq.size() > 0) check("data", {28'd0, bus.out_data}, {28'd0, mq[0]});
  endtask

  task automatic step(input logic se, input logic sd, input logic fs, input logic rdy);
    bus.ser_en     = se;
    bus.ser_data   = sd;
    bus.frame_sync = fs;
    bus.out_ready  = rdy;
    model_step(se, sd, fs, rdy);
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Send one word LSB first, idling `gap` cycles between bits; last_rdy is
  // out_ready on the completing bit's cycle.
  task automatic send_word(input logic [W-1:0] w, input int gap, input logic rdy,
                           input logic last_rdy);
    for (int i = 0; i < int'(W); i++) begin
      step(1'b1, w[i], 1'b0, (i == int'(W) - 1) ? last_rdy : rdy);
      if (i < int'(W) - 1) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0, rdy);
      end
    end
  endtask

  task automatic drain_check(input string tag, input logic [W-1:0] exp[$]);
    logic [W-1:0] got[$];
    for (int i = 0; i < 16; i++) begin
      if (!bus.out_valid) break;
      got.push_back(bus.out_data);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), {28'd0, got[i]}, {28'd0, exp[i]});
    end
  endtask

  initial begin
    bus.ser_en     = 1'b0;
    bus.ser_data   = 1'b0;
    bus.frame_sync = 1'b0;
    bus.out_ready  = 1'b0;
    rst            = 1'b0;

    // Reset values
    do_reset(2);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_data", {28'd0, bus.out_data}, 32'd0);
    check("rst_fill", {29'd0, bus.fill_level}, 32'd0);
    check("rst_flags", {30'd0, bus.overflow, bus.frame_err}, 32'd0);

    // Single word 1,1,0,1 -> B, held while not ready, then popped
    send_word(4'hB, 0, 1'b0, 1'b0);
    check("single_valid", {31'd0, bus.out_valid}, 32'd1);
    check("single_data", {28'd0, bus.out_data}, 32'hB);
    check("single_fill", {29'd0, bus.fill_level}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'($urandom), 1'b0, 1'b0);
      check("single_hold", {28'd0, bus.out_data}, 32'hB);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("single_pop_valid", {31'd0, bus.out_valid}, 32'd0);
    check("single_pop_fill", {29'd0, bus.fill_level}, 32'd0);

    // Gapped strobes 0,1,1,1 -> E
    send_word(4'hE, 3, 1'b0, 1'b0);
    check("gap_fill", {29'd0, bus.fill_level}, 32'd1);
    check("gap_data", {28'd0, bus.out_data}, 32'hE);
    drain_check("gap_drain", '{4'hE});

    // Overflow: fifth word dropped
    do_reset(1);
    for (int k = 1; k <= 5; k++) send_word(W'(k), 0, 1'b0, 1'b0);
    check("ovf_fill", {29'd0, bus.fill_level}, 32'd4);
    check("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    drain_check("ovf_drain", '{4'h1, 4'h2, 4'h3, 4'h4});

    // Full FIFO with a same-cycle pop accepts the fifth word
    do_reset(1);
    for (int k = 1; k <= 4; k++) send_word(W'(k), 0, 1'b0, 1'b0);
    send_word(4'h5, 0, 1'b0, 1'b1);
    check("full_pop_fill", {29'd0, bus.fill_level}, 32'd4);
    check("full_pop_ovf", {31'd0, bus.overflow}, 32'd0);
    drain_check("full_pop_drain", '{4'h2, 4'h3, 4'h4, 4'h5});

    // Framing abort mid-word; the strobed bit with frame_sync is discarded
    do_reset(1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("frame_err_set", {31'd0, bus.frame_err}, 32'd1);
    check("frame_no_push", {29'd0, bus.fill_level}, 32'd0);
    send_word(4'h6, 0, 1'b0, 1'b0);
    drain_check("frame_drain", '{4'h6});
    do_reset(1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("frame_idle_ok", {31'd0, bus.frame_err}, 32'd0);

    // Reset mid-operation discards buffered and partial words
    send_word(4'h3, 0, 1'b0, 1'b0);
    send_word(4'h7, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset(1);
    check("midrst_fill", {29'd0, bus.fill_level}, 32'd0);
    check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_flags", {30'd0, bus.overflow, bus.frame_err}, 32'd0);
    send_word(4'h9, 0, 1'b0, 1'b0);
    drain_check("midrst_drain", '{4'h9});

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom), ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 9) < 4));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
